refresh_scheduler: RTL and testbench



---
 rtl/refresh_scheduler.sv | 142 ++++++++++++++
 tb/tb_refresh_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: counts owed SDRAM auto-refreshes from rising edges of
// REFRESH_STROBE, requests the command bus through REQ/GNT, issues one-cycle
// CMD_REFRESH pulses and holds REF_BUSY for T_RFC cycles per refresh.
// Optional macro REFRESH_BURST_EN: chain refreshes straight from WAIT_RFC into
// CMD while refreshes are owed and the grant is still held.
module refresh_scheduler #(
  parameter int CNT_W        = 4,
  parameter int MAX_PENDING  = 8,
  parameter int URGENT_LEVEL = 6,
  parameter int T_RFC        = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REFRESH_STROBE,
  input  logic             REF_GNT,
  output logic             REF_REQ,
  output logic             REF_URGENT,
  output logic             CMD_REFRESH,
  output logic             REF_BUSY,
  output logic [CNT_W-1:0] PENDING,
  output logic             OVERFLOW
);

  localparam int RFC_W = (T_RFC > 2) ? $clog2(T_RFC) : 1;
  localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] URG_P    = CNT_W'(URGENT_LEVEL);
  localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(T_RFC - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CMD  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_strobe_q;
  logic [CNT_W-1:0]  r_pending;
  logic              r_overflow;
  logic [RFC_W-1:0]  r_rfc_cnt;
  logic              w_edge;
  logic              w_dec;

  // A strobe already high when reset releases must not count, hence reset to 1.
  assign w_edge = REFRESH_STROBE & ~r_strobe_q;
  // The refresh is paid for in the cycle the command is on the bus.
  assign w_dec  = (r_state == S_CMD);

  // State register and previous-strobe sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_strobe_q <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_strobe_q <= REFRESH_STROBE;
    end
  end

  // Saturating owed-refresh count with sticky overflow; a simultaneous edge and
  // command cancel out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_edge, w_dec})
        2'b10: begin
          if (r_pending == MAX_P) begin
            r_overflow <= 1'b1;
          end else begin
            r_pending <= r_pending + 1'b1;
          end
        end
        2'b01: begin
          if (r_pending != '0) begin
            r_pending <= r_pending - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // tRFC counter: loaded in CMD, counts down through WAIT_RFC to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rfc_cnt <= '0;
    end else if (r_state == S_CMD) begin
      r_rfc_cnt <= RFC_LOAD;
    end else if (r_state == S_WAIT && r_rfc_cnt != '0) begin
      r_rfc_cnt <= r_rfc_cnt - 1'b1;
    end
  end

  // Next-state decode and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    REF_REQ      = 1'b0;
    CMD_REFRESH  = 1'b0;
    REF_BUSY     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending != '0) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        REF_REQ = 1'b1;
        if (REF_GNT) begin
          w_state_next = S_CMD;
        end
      end
      S_CMD: begin
        CMD_REFRESH  = 1'b1;
        REF_BUSY     = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        REF_BUSY = 1'b1;
        if (r_rfc_cnt == '0) begin
`ifdef REFRESH_BURST_EN
          if (r_pending != '0 && REF_GNT) begin
            w_state_next = S_CMD;
          end else begin
            w_state_next = S_IDLE;
          end
`else
          w_state_next = S_IDLE;
`endif
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign REF_URGENT = (r_pending >= URG_P);
  assign PENDING    = r_pending;
  assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed testbench for refresh_scheduler (default parameters).
module tb_refresh_scheduler;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic       gnt;
  logic       ref_req;
  logic       ref_urgent;
  logic       cmd_refresh;
  logic       ref_busy;
  logic [3:0] pending;
  logic       overflow;

  int pass_cnt;
  int total_cnt;

`ifdef REFRESH_BURST_EN
  localparam int EXP_SPACING = 15;
  localparam int EXP_MAX_RUN = 120;
`else
  localparam int EXP_SPACING = 17;
  localparam int EXP_MAX_RUN = 15;
`endif

  refresh_scheduler dut (
    .CLK            (clk),
    .RST            (rst),
    .REFRESH_STROBE (strobe),
    .REF_GNT        (gnt),
    .REF_REQ        (ref_req),
    .REF_URGENT     (ref_urgent),
    .CMD_REFRESH    (cmd_refresh),
    .REF_BUSY       (ref_busy),
    .PENDING        (pending),
    .OVERFLOW       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with the strobe already high: nothing may be counted afterwards.
  task automatic test_reset();
    int bad;
    rst    = 1'b1;
    strobe = 1'b1;
    gnt    = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({ref_req, ref_urgent, cmd_refresh, ref_busy, pending, overflow} !== 9'd0)
      $display("FAIL reset_outputs: got %b required 0",
               {ref_req, ref_urgent, cmd_refresh, ref_busy, pending, overflow});
    else pass_cnt++;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pending !== 4'd0 || ref_req !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL reset_strobe_high: %0d bad cycles, required 0", bad);
    else pass_cnt++;
    strobe = 1'b0;
    @(negedge clk);
    $display("test_reset done: pending=%0d req=%0b", pending, ref_req);
  endtask

  // One strobe edge with grant tied high.
  task automatic test_single();
    int n_req, n_cmd, n_busy, pend_at_cmd;
    gnt    = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (pending !== 4'd1 || ref_req !== 1'b0)
      $display("FAIL single_latency: pending=%0d req=%0b required pending=1 req=0", pending, ref_req);
    else pass_cnt++;
    strobe = 1'b0;
    n_req = 0; n_cmd = 0; n_busy = 0; pend_at_cmd = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ref_req === 1'b1) n_req++;
      if (cmd_refresh === 1'b1) begin
        n_cmd++;
        pend_at_cmd = int'(pending);
      end
      if (ref_busy === 1'b1) n_busy++;
    end
    total_cnt++;
    if (n_cmd != 1) $display("FAIL single_cmd_count: got %0d required 1", n_cmd);
    else pass_cnt++;
    total_cnt++;
    if (n_busy != 15) $display("FAIL single_busy_cycles: got %0d required 15", n_busy);
    else pass_cnt++;
    total_cnt++;
    if (n_req != 1) $display("FAIL single_req_cycles: got %0d required 1", n_req);
    else pass_cnt++;
    total_cnt++;
    if (pend_at_cmd != 1 || pending !== 4'd0)
      $display("FAIL single_pending: at_cmd=%0d final=%0d required 1 and 0", pend_at_cmd, pending);
    else pass_cnt++;
    $display("test_single done: cmd=%0d busy=%0d req=%0d", n_cmd, n_busy, n_req);
  endtask

  // Nine strobe edges with no grant: saturation, urgency, overflow.
  task automatic test_saturate();
    int exp_p;
    gnt = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      strobe = 1'b1;
      @(negedge clk);
      exp_p = (k > 8) ? 8 : k;
      total_cnt++;
      if (pending !== 4'(exp_p) || ref_urgent !== (exp_p >= 6))
        $display("FAIL sat_edge%0d: pending=%0d urgent=%0b required %0d/%0b",
                 k, pending, ref_urgent, exp_p, (exp_p >= 6));
      else pass_cnt++;
      strobe = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (ref_req !== 1'b1 || overflow !== (k == 9))
        $display("FAIL sat_req_ovf%0d: req=%0b ovf=%0b required 1/%0b", k, ref_req, overflow, (k == 9));
      else pass_cnt++;
    end
    $display("test_saturate done: pending=%0d overflow=%0b", pending, overflow);
  endtask

  // Drain eight owed refreshes with grant held high.
  task automatic test_drain();
    int pulses, last_c, spacing_bad, run, max_run, urg_bad, prev_p;
    bit prev_u, saw_fall;
    pulses = 0; last_c = 0; spacing_bad = 0; run = 0; max_run = 0; urg_bad = 0;
    prev_p = int'(pending); prev_u = ref_urgent; saw_fall = 0;
    gnt = 1'b1;
    for (int c = 0; c < 170; c++) begin
      @(negedge clk);
      if (cmd_refresh === 1'b1) begin
        if (pulses > 0 && (c - last_c) != EXP_SPACING) spacing_bad++;
        last_c = c;
        pulses++;
      end
      if (ref_busy === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (ref_urgent !== (int'(pending) >= 6)) urg_bad++;
      if (prev_p == 6 && pending === 4'd5 && prev_u && ref_urgent === 1'b0) saw_fall = 1;
      prev_p = int'(pending);
      prev_u = ref_urgent;
    end
    total_cnt++;
    if (pulses != 8) $display("FAIL drain_pulses: got %0d required 8", pulses);
    else pass_cnt++;
    total_cnt++;
    if (spacing_bad != 0) $display("FAIL drain_spacing: %0d bad gaps, required spacing %0d", spacing_bad, EXP_SPACING);
    else pass_cnt++;
    total_cnt++;
    if (max_run != EXP_MAX_RUN) $display("FAIL drain_busy_run: got %0d required %0d", max_run, EXP_MAX_RUN);
    else pass_cnt++;
    total_cnt++;
    if (pending !== 4'd0 || ref_req !== 1'b0)
      $display("FAIL drain_final: pending=%0d req=%0b required 0/0", pending, ref_req);
    else pass_cnt++;
    total_cnt++;
    if (urg_bad != 0 || !saw_fall)
      $display("FAIL drain_urgent: bad=%0d fall_seen=%0b required 0/1", urg_bad, saw_fall);
    else pass_cnt++;
    $display("test_drain done: pulses=%0d max_busy_run=%0d", pulses, max_run);
  endtask

  // Strobe edge in the CMD cycle, then asynchronous reset mid-WAIT_RFC.
  task automatic test_coincident_reset();
    gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      @(negedge clk);
    end
    gnt = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (cmd_refresh !== 1'b1 || pending !== 4'd3)
      $display("FAIL coinc_cmd: cmd=%0b pending=%0d required 1/3", cmd_refresh, pending);
    else pass_cnt++;
    strobe = 1'b1;
    gnt    = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (pending !== 4'd3 || ref_busy !== 1'b1 || cmd_refresh !== 1'b0)
      $display("FAIL coinc_pending: pending=%0d busy=%0b cmd=%0b required 3/1/0", pending, ref_busy, cmd_refresh);
    else pass_cnt++;
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ref_busy !== 1'b1 || overflow !== 1'b1)
      $display("FAIL pre_reset: busy=%0b ovf=%0b required 1/1", ref_busy, overflow);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({ref_req, ref_urgent, cmd_refresh, ref_busy, pending, overflow} !== 9'd0)
      $display("FAIL async_reset: got %b required 0",
               {ref_req, ref_urgent, cmd_refresh, ref_busy, pending, overflow});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ref_req !== 1'b0 || ref_busy !== 1'b0 || pending !== 4'd0)
      $display("FAIL post_reset_idle: req=%0b busy=%0b pending=%0d required 0/0/0", ref_req, ref_busy, pending);
    else pass_cnt++;
    $display("test_coincident_reset done: pending=%0d overflow=%0b", pending, overflow);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    strobe    = 1'b1;
    gnt       = 1'b0;
    test_reset();
    test_single();
    test_saturate();
    test_drain();
    test_coincident_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
